hd44780_bus_ctrl: RTL
=====================

# hd44780_bus_ctrl

Parametrised HD44780 character-LCD bus controller; successor to the fixed 8-bit LCD writer. Accepts single command/data transfers, read or write, from a sequencer over a req/ack handshake. Drives the LCD E/RW/RS/D[7:0] pins in 8-bit or 4-bit mode with programmable setup and E-pulse widths. Polls the busy flag after each transfer, with a bounded poll count and a timeout indication. Sits between the demo/sequencer FSM and the top-level pin tristates.

## Interface
- BUS_WIDTH, 8, LCD data bus width; legal values 8 or 4.
- SETUP_CYCLES, 1, clocks RS/RW/data are stable before E rises (>=1).
- E_HIGH_CYCLES, 2, clocks E is held high per pulse (>=1).
- BF_TIMEOUT, 1023, maximum busy-flag polls per transfer; 0 = never poll (RW pin unused).

- clock  in  1  single clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  1  transfer request; sampled only in IDLE.
- rs_sel  in  1  0 = instruction register, 1 = data register.
- rnw  in  1  1 = read transfer, 0 = write transfer.
- single  in  1  4-bit mode only: send high nibble only, no BF poll (init sequence); ignored when BUS_WIDTH=8.
- wdata  in  8  write value.
- ack  out  1  one-cycle completion pulse.
- timeout  out  1  valid with ack; 1 = busy flag still set after BF_TIMEOUT polls.
- rdata  out  8  value of last completed read; held until the next read completes.
- busy  out  1  high from acceptance until ack (inclusive of the ack cycle).
- e, rw, rs  out  1 each  LCD control pins.
- lcd_dout  out  8  pin drive value; in 4-bit mode only [7:4] used, [3:0] = 0.
- lcd_oe  out  1  1 = drive D pins; tristating is done at top level.
- lcd_din  in  8  pin sample value.

## Operation
- Reset: e=0, rw=0, rs=0, lcd_oe=0, lcd_dout=0, ack=0, timeout=0, rdata=0, busy=0, FSM to IDLE, counters cleared. Reset mid-transfer drops E immediately; no partial completion, no ack.
- IDLE: on req=1, latch rs_sel/rnw/single/wdata, set nibble index to high, go to SETUP. req in any other state is ignored (no queueing).
- SETUP (SETUP_CYCLES): e=0; rs=latched rs_sel; rw=rnw; lcd_oe=~rnw; lcd_dout = wdata (8-bit) or current nibble on [7:4].
- EHIGH (E_HIGH_CYCLES): e=1. For reads, sample lcd_din on the last EHIGH cycle: whole byte (8-bit), or [7:4] into high/low half of the read shift register (4-bit).
- HOLD (1 cycle): e=0, rs/rw/data unchanged. Then: 4-bit, high nibble done, single=0 -> SETUP for low nibble. Else if single=1 or BF_TIMEOUT=0 -> ACK. Else -> BF_SETUP.
- BF_SETUP / BF_EHIGH / BF_HOLD: same cycle counts with rs=0, rw=1, lcd_oe=0. Busy flag = lcd_din[7] on the last BF_EHIGH cycle. In 4-bit mode a second dummy nibble pulse (same timing) follows and its sample is discarded. Poll count increments per poll.
- After BF_HOLD: flag clear -> ACK, timeout=0. Flag set and polls < BF_TIMEOUT -> BF_SETUP. Flag set and polls = BF_TIMEOUT -> ACK, timeout=1.
- ACK (1 cycle): ack=1; rdata updated on a read; then back to IDLE with rw=0, lcd_oe=0.
- A read with rs_sel=0 returns BF+address. BF polling still follows any read.

## Timing
- Phase P = SETUP_CYCLES + E_HIGH_CYCLES + 1 clocks.
- ack is high on cycle N after the acceptance edge, where:
  - 8-bit, BF clear on first poll: N = 2P + 1 (defaults: 9).
  - 4-bit: N = 4P + 1.
  - 4-bit with single=1: N = P + 1.
  - BF_TIMEOUT = 0: N = P + 1 (8-bit) or 2P + 1 (4-bit).
- Each additional poll adds P (8-bit) or 2P (4-bit) clocks.
- Earliest next acceptance is the cycle after ack. E low time between pulses is at least SETUP_CYCLES + 1 clocks.
- Poll counter width is clog2(BF_TIMEOUT+1). It saturates and never wraps.

## Structure
- Shared package hd44780_pkg:
  - FSM state enum (IDLE, SETUP, EHIGH, HOLD, BF_SETUP, BF_EHIGH, BF_HOLD, ACK).
  - RS_CMD/RS_DATA constants.
  - Command constants: CLEAR 8'h01, ENTRY_INC 8'h06, DISP_ON_CUR_BLINK 8'h0F, FUNC_8BIT_2LINE 8'h38, FUNC_4BIT_2LINE 8'h28.
- Sub-module hd44780_phase_timer: loadable down-counter (load SETUP_CYCLES or E_HIGH_CYCLES, done pulse). It is shared by the transfer and BF phases.

## Test plan
- 8-bit, defaults, write 8'h38 rs=0, BF model clear -> E high exactly 2 clocks, lcd_dout=8'h38 with lcd_oe=1 through HOLD, ack on cycle 9, timeout=0.
- 8-bit, BF model busy for 3 polls then clear -> 4 BF pulses seen, ack on cycle 9+3*4=21.
- BUS_WIDTH=4, write data 8'h48 rs=1 -> nibbles 4 then 8 on lcd_dout[7:4], rs=1 on both, ack on cycle 17. Separately, single=1 with wdata 8'h30 -> one pulse only, ack on cycle 5.
- Read, rs=1, model drives 8'hA5 (4-bit: A then 5) -> rdata=8'hA5 at ack; lcd_oe=0 throughout.
- BF_TIMEOUT=4, BF stuck high -> exactly 4 polls, then ack with timeout=1; next request is accepted normally.
- Assert reset during EHIGH of a transfer -> e, lcd_oe, busy low immediately, no ack. req=1 held during busy is ignored; a req after reset completes normally.

Source files
------------

// File: rtl/hd44780_pkg.sv
// Shared FSM state type, register-select values and common HD44780 command bytes
// used by the bus controller and by the sequencers that drive it.
package hd44780_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        EHIGH,
        HOLD,
        BF_SETUP,
        BF_EHIGH,
        BF_HOLD,
        ACK
    } state_e;

    localparam logic RS_CMD  = 1'b0;
    localparam logic RS_DATA = 1'b1;

    localparam logic [7:0] CLEAR             = 8'h01;
    localparam logic [7:0] ENTRY_INC         = 8'h06;
    localparam logic [7:0] DISP_ON_CUR_BLINK = 8'h0F;
    localparam logic [7:0] FUNC_8BIT_2LINE   = 8'h38;
    localparam logic [7:0] FUNC_4BIT_2LINE   = 8'h28;

    function automatic int maxOf(input int a, input int b);
        maxOf = (a > b) ? a : b;
    endfunction

    // In 4-bit mode the LCD only listens on D[7:4]; the unused lines are held low.
    function automatic logic [7:0] nibbleOnBus(input logic [7:0] value, input logic hiNib);
        nibbleOnBus = {(hiNib ? value[7:4] : value[3:0]), 4'b0000};
    endfunction

endpackage

// File: rtl/hd44780_phase_timer.sv
// Loadable down-counter timing the SETUP and E-high phases of both the transfer
// and the busy-flag pulses; done_o marks the last cycle of the current phase.
module hd44780_phase_timer #(
    parameter int W = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] loadVal_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = loadVal_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/hd44780_bus_ctrl.sv
// HD44780 character-LCD bus controller: one command/data transfer per req/ack
// handshake in 8- or 4-bit mode, followed by bounded busy-flag polling.
module hd44780_bus_ctrl
    import hd44780_pkg::*;
#(
    parameter int BUS_WIDTH     = 8,
    parameter int SETUP_CYCLES  = 1,
    parameter int E_HIGH_CYCLES = 2,
    parameter int BF_TIMEOUT    = 1023
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       req_i,
    input  logic       rs_sel_i,
    input  logic       rnw_i,
    input  logic       single_i,
    input  logic [7:0] wdata_i,
    output logic       ack_o,
    output logic       timeout_o,
    output logic [7:0] rdata_o,
    output logic       busy_o,
    output logic       e_o,
    output logic       rw_o,
    output logic       rs_o,
    output logic [7:0] lcd_dout_o,
    output logic       lcd_oe_o,
    input  logic [7:0] lcd_din_i
);

    localparam bit NIBBLE_MODE = (BUS_WIDTH == 4);
    localparam int TW = $clog2(maxOf(SETUP_CYCLES, E_HIGH_CYCLES) + 1);
    localparam int PW = (BF_TIMEOUT > 0) ? $clog2(BF_TIMEOUT + 1) : 1;

    localparam logic [TW-1:0] SETUP_LOAD = TW'(SETUP_CYCLES - 1);
    localparam logic [TW-1:0] EHIGH_LOAD = TW'(E_HIGH_CYCLES - 1);
    localparam logic [PW-1:0] POLL_LAST  = PW'((BF_TIMEOUT > 0) ? BF_TIMEOUT - 1 : 0);
    localparam logic [PW-1:0] POLL_MAX   = PW'(BF_TIMEOUT);

    state_e state_q, state_d;

    logic          rsSel_q, rsSel_d;
    logic          rnw_q, rnw_d;
    logic          single_q, single_d;
    logic [7:0]    wdata_q, wdata_d;
    logic          nibHi_q, nibHi_d;
    logic          bfNibHi_q, bfNibHi_d;
    logic          bfFlag_q, bfFlag_d;
    logic [PW-1:0] pollCnt_q, pollCnt_d;
    logic          timeout_q, timeout_d;
    logic [7:0]    rdShift_q, rdShift_d;
    logic [7:0]    rdata_q, rdata_d;

    logic          timerLoad;
    logic [TW-1:0] timerVal;
    logic          timerDone;

    hd44780_phase_timer #(
        .W(TW)
    ) u_phase_timer (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .load_i   (timerLoad),
        .loadVal_i(timerVal),
        .done_o   (timerDone)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rsSel_q   <= 1'b0;
            rnw_q     <= 1'b0;
            single_q  <= 1'b0;
            wdata_q   <= '0;
            nibHi_q   <= 1'b1;
            bfNibHi_q <= 1'b1;
            bfFlag_q  <= 1'b0;
            pollCnt_q <= '0;
            timeout_q <= 1'b0;
            rdShift_q <= '0;
            rdata_q   <= '0;
        end else begin
            rsSel_q   <= rsSel_d;
            rnw_q     <= rnw_d;
            single_q  <= single_d;
            wdata_q   <= wdata_d;
            nibHi_q   <= nibHi_d;
            bfNibHi_q <= bfNibHi_d;
            bfFlag_q  <= bfFlag_d;
            pollCnt_q <= pollCnt_d;
            timeout_q <= timeout_d;
            rdShift_q <= rdShift_d;
            rdata_q   <= rdata_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rsSel_d   = rsSel_q;
        rnw_d     = rnw_q;
        single_d  = single_q;
        wdata_d   = wdata_q;
        nibHi_d   = nibHi_q;
        bfNibHi_d = bfNibHi_q;
        bfFlag_d  = bfFlag_q;
        pollCnt_d = pollCnt_q;
        timeout_d = timeout_q;
        rdShift_d = rdShift_q;
        rdata_d   = rdata_q;

        unique case (state_q)
            IDLE: begin
                if (req_i) begin
                    state_d   = SETUP;
                    rsSel_d   = rs_sel_i;
                    rnw_d     = rnw_i;
                    single_d  = NIBBLE_MODE && single_i;
                    wdata_d   = wdata_i;
                    nibHi_d   = 1'b1;
                    bfNibHi_d = 1'b1;
                    pollCnt_d = '0;
                    timeout_d = 1'b0;
                end
            end
            SETUP: begin
                if (timerDone) begin
                    state_d = EHIGH;
                end
            end
            EHIGH: begin
                if (timerDone) begin
                    state_d = HOLD;
                    if (rnw_q) begin
                        if (!NIBBLE_MODE) begin
                            rdShift_d = lcd_din_i;
                        end else if (nibHi_q) begin
                            rdShift_d[7:4] = lcd_din_i[7:4];
                        end else begin
                            rdShift_d[3:0] = lcd_din_i[7:4];
                        end
                    end
                end
            end
            HOLD: begin
                if (NIBBLE_MODE && nibHi_q && !single_q) begin
                    state_d = SETUP;
                    nibHi_d = 1'b0;
                end else if (single_q || (BF_TIMEOUT == 0)) begin
                    state_d = ACK;
                end else begin
                    state_d = BF_SETUP;
                end
            end
            BF_SETUP: begin
                if (timerDone) begin
                    state_d = BF_EHIGH;
                end
            end
            BF_EHIGH: begin
                if (timerDone) begin
                    state_d = BF_HOLD;
                    if (bfNibHi_q) begin
                        bfFlag_d = lcd_din_i[7];
                    end
                end
            end
            BF_HOLD: begin
                // In 4-bit mode the second (address low) nibble is clocked out and dropped.
                if (NIBBLE_MODE && bfNibHi_q) begin
                    state_d   = BF_SETUP;
                    bfNibHi_d = 1'b0;
                end else begin
                    bfNibHi_d = 1'b1;
                    if (pollCnt_q != POLL_MAX) begin
                        pollCnt_d = pollCnt_q + PW'(1);
                    end
                    if (!bfFlag_q) begin
                        state_d = ACK;
                    end else if (pollCnt_q < POLL_LAST) begin
                        state_d = BF_SETUP;
                    end else begin
                        state_d   = ACK;
                        timeout_d = 1'b1;
                    end
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // rdata must already hold the new value during the ack cycle.
        if ((state_d == ACK) && (state_q != ACK) && rnw_q) begin
            rdata_d = rdShift_q;
        end
    end

    always_comb begin
        timerLoad = (state_d != state_q);
        timerVal  = '0;
        unique case (state_d)
            SETUP, BF_SETUP: timerVal = SETUP_LOAD;
            EHIGH, BF_EHIGH: timerVal = EHIGH_LOAD;
            default:         timerVal = '0;
        endcase
    end

    always_comb begin
        e_o        = 1'b0;
        rw_o       = 1'b0;
        rs_o       = 1'b0;
        lcd_oe_o   = 1'b0;
        lcd_dout_o = '0;
        unique case (state_q)
            SETUP, EHIGH, HOLD: begin
                rs_o       = rsSel_q;
                rw_o       = rnw_q;
                lcd_oe_o   = ~rnw_q;
                lcd_dout_o = NIBBLE_MODE ? nibbleOnBus(wdata_q, nibHi_q) : wdata_q;
                e_o        = (state_q == EHIGH);
            end
            BF_SETUP, BF_EHIGH, BF_HOLD: begin
                rw_o = 1'b1;
                e_o  = (state_q == BF_EHIGH);
            end
            default: begin
                e_o = 1'b0;
            end
        endcase
    end

    assign ack_o     = (state_q == ACK);
    assign timeout_o = (state_q == ACK) && timeout_q;
    assign busy_o    = (state_q != IDLE);
    assign rdata_o   = rdata_q;

endmodule
